// File: rtl/mem_stage.sv
// Load/store stage: checks alignment, runs one data-memory access at a time
// under a timeout, and registers the writeback result.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dataW_i,
  input  logic [4:0]  rd_i,
  input  logic        regwen_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_regwen_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_funct3;
  logic [1:0]    r_lo;
  logic [4:0]    r_rd;
  logic          r_regwen;

  logic        w_mem, w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_mem = mem_rd_i | mem_wr_i;

  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = dataW_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{dataW_i[7:0]}};
      end
      2'b01: begin
        w_misal = addr_i[0];
        w_be    = 4'b0011 << addr_i[1:0];
        w_wdata = {2{dataW_i[15:0]}};
      end
      default: w_misal = |addr_i[1:0];
    endcase
    // Loads always fetch the full word; the lane is picked on return.
    if (!mem_wr_i) w_be = 4'b1111;
  end

  always_comb begin
    case (r_lo)
      2'd0:    w_byte = dmem_rdata_i[7:0];
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      default: w_byte = dmem_rdata_i[31:24];
    endcase
    w_half = r_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem_rdata_i;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      if (r_state == S_IDLE) stall_o = valid_i & w_mem & ~w_misal;
      else                   stall_o = ~dmem_ack_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_funct3     <= '0;
      r_lo         <= '0;
      r_rd         <= '0;
      r_regwen     <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      wb_rd_o      <= '0;
      wb_regwen_o  <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (r_state)
        S_IDLE: if (valid_i) begin
          if (!w_mem) begin
            wb_valid_o  <= 1'b1;
            wb_data_o   <= addr_i;
            wb_rd_o     <= rd_i;
            wb_regwen_o <= regwen_i;
          end else if (w_misal) begin
            misalign_o  <= 1'b1;
            wb_valid_o  <= 1'b1;
            wb_data_o   <= '0;
            wb_rd_o     <= rd_i;
            wb_regwen_o <= 1'b0;
          end else begin
            r_state      <= S_ACCESS;
            r_cnt        <= '0;
            r_funct3     <= funct3_i;
            r_lo         <= addr_i[1:0];
            r_rd         <= rd_i;
            r_regwen     <= regwen_i & ~mem_wr_i;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_wr_i;
            dmem_addr_o  <= {addr_i[31:2], 2'b00};
            dmem_wdata_o <= w_wdata;
            dmem_be_o    <= w_be;
          end
        end
        S_ACCESS: begin
          // Ack wins over a timeout landing in the same cycle.
          if (dmem_ack_i) begin
            r_state     <= S_IDLE;
            dmem_req_o  <= 1'b0;
            wb_valid_o  <= 1'b1;
            wb_data_o   <= dmem_we_o ? 32'd0 : w_load;
            wb_rd_o     <= r_rd;
            wb_regwen_o <= r_regwen;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= S_IDLE;
            dmem_req_o  <= 1'b0;
            bus_err_o   <= 1'b1;
            wb_valid_o  <= 1'b1;
            wb_data_o   <= '0;
            wb_rd_o     <= r_rd;
            wb_regwen_o <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the number of ACCESS-state cycles without dmem_ack_i before the access is aborted.
REQ-002 SHALL have clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have valid_i  in  1  instruction present in MEM stage.
REQ-005 SHALL have mem_rd_i / mem_wr_i  in  1 each  load / store instruction.
REQ-006 SHALL have funct3_i  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 SHALL have addr_i  in  32  ALU result (effective address or non-memory result).
REQ-008 SHALL have dataW_i  in  32  store data from operand-select stage.
REQ-009 SHALL have rd_i  in  5, regwen_i  in  1  destination register and write enable.
REQ-010 SHALL have dmem_req_o  out  1, dmem_we_o  out  1, dmem_addr_o  out  32 (bits 1:0 = 0), dmem_wdata_o  out  32, dmem_be_o  out  4  data-memory request.
REQ-011 SHALL have dmem_ack_i  in  1, dmem_rdata_i  in  32  data-memory response.
REQ-012 SHALL have stall_o  out  1  upstream must hold all inputs while high.
REQ-013 SHALL have wb_valid_o  out  1, wb_data_o  out  32, wb_rd_o  out  5, wb_regwen_o  out  1  registered writeback outputs.
REQ-014 SHALL have misalign_o  out  1, bus_err_o  out  1  single-cycle exception pulses.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS.
REQ-016 In IDLE with valid_i=1 and mem_rd_i=mem_wr_i=0: SHALL register wb_data_o=addr_i, wb_rd_o=rd_i, wb_regwen_o=regwen_i, wb_valid_o=1 on the next edge (latency 1); stall_o=0.
REQ-017 In IDLE with a memory op: SHALL check alignment -- half: addr_i[0]=0; word: addr_i[1:0]=00; byte: always aligned.
REQ-018 Misaligned op: SHALL issue no request; next cycle misalign_o=1, wb_valid_o=1, wb_regwen_o=0; stall_o=0.
REQ-019 Aligned op: stall_o=1 combinationally in the accept cycle; next edge SHALL enter ACCESS with dmem_req_o=1 and all dmem_* outputs registered.
REQ-020 dmem_addr_o SHALL be {addr_i[31:2],2'b00}; dmem_we_o=mem_wr_i; mem_wr_i=mem_rd_i=1 SHALL be treated as a store.
REQ-021 Store byte lanes: SB be=0001<<addr[1:0], wdata=dataW_i[7:0] replicated x4; SH be=0011<<addr[1:0], wdata=dataW_i[15:0] replicated x2; SW be=1111, wdata=dataW_i. Loads: be=1111.
REQ-022 In ACCESS, dmem_* outputs SHALL remain stable until ack; stall_o=1 while dmem_ack_i=0, stall_o=0 in the ack cycle.
REQ-023 On dmem_ack_i=1 in ACCESS: next edge SHALL deassert dmem_req_o, return to IDLE, assert wb_valid_o=1 with wb_rd_o/wb_regwen_o captured at accept (store: wb_regwen_o=0).
REQ-024 Load data: SHALL select byte/half of dmem_rdata_i by captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-025 dmem_ack_i while in IDLE SHALL be ignored.
REQ-026 Wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ack; on reaching TIMEOUT_CYCLES: drop dmem_req_o, return to IDLE, pulse bus_err_o=1 with wb_valid_o=1, wb_regwen_o=0.
REQ-027 Ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success (no bus_err_o).
REQ-028 wb_valid_o, misalign_o, bus_err_o SHALL be 0 in every cycle not listed above.

Reset
REQ-029 rst=1 SHALL force on the next edge: state IDLE, counter 0, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, dmem_be_o=0, wb_valid_o=0, wb_data_o=0, wb_rd_o=0, wb_regwen_o=0, misalign_o=0, bus_err_o=0.
REQ-030 rst during ACCESS SHALL abandon the access with no writeback and no bus_err_o; stall_o=0 while rst=1.

Verification
REQ-031 Non-mem op addr_i=0x0000_1234, rd_i=5, regwen_i=1 -> next cycle wb_valid_o=1, wb_data_o=0x0000_1234, wb_rd_o=5, stall_o never 1.
REQ-032 LB addr_i=0x103, ack after 3 cycles with rdata=0x80FF_FFFF -> dmem_addr_o=0x100, stall_o=1 for 4 cycles, wb_data_o=0xFFFF_FF80; repeat as LBU -> 0x0000_0080.
REQ-033 SH addr_i=0x202, dataW_i=0xDEAD_BEEF, ack immediate -> dmem_be_o=1100, dmem_wdata_o=0xBEEF_BEEF, dmem_we_o=1, wb_regwen_o=0.
REQ-034 LW addr_i=0x101 -> no dmem_req_o, misalign_o=1 one cycle, wb_regwen_o=0.
REQ-035 LW, ack never arrives -> dmem_req_o drops after 15 ACCESS cycles, bus_err_o=1 one cycle, FSM back in IDLE.
REQ-036 rst=1 in 2nd ACCESS cycle, then late ack -> dmem_req_o=0 next edge, no wb_valid_o, ack ignored.
